// File: rtl/johnson_seq_ctrl_if.sv
// johnson_seq_ctrl_if: control/status bundle between a sequencer and its controller
interface johnson_seq_ctrl_if #(parameter int WIDTH = 4, parameter int CNT_W = 8);
  logic start, stop, mode, dir;
  logic [CNT_W-1:0] num_cycles;
  logic [WIDTH-1:0] q;
  logic [2*WIDTH-1:0] phase_en;
  logic busy, wrap, done, err;
  modport master (output start, stop, mode, dir, num_cycles, input q, phase_en, busy, wrap, done, err);
  modport slave (input start, stop, mode, dir, num_cycles, output q, phase_en, busy, wrap, done, err);
endinterface

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: Johnson ring sequencer with burst/continuous modes and phase enables
// Optional JOHNSON_SELF_CORRECT_EN: illegal ring codes are forced back to zero with an err pulse.
module johnson_seq_ctrl #(parameter int WIDTH = 4, parameter int CNT_W = 8) (
  input logic clk,
  input logic rst,
  johnson_seq_ctrl_if.slave bus
);
  localparam int IW = $clog2(2*WIDTH);
  localparam logic [IW-1:0] LAST = IW'(2*WIDTH-1);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] q_r, q_n, q_adv;
  logic [IW-1:0] idx, idx_n, idx_adv;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2*WIDTH-1:0] pe_r, pe_n;
  logic mode_l, mode_n, dir_l, dir_n;
  logic busy_r, busy_n, wrap_r, wrap_n, done_r, done_n, err_r, err_n;
  logic illegal;
  assign q_adv = dir_l ? {~q_r[0], q_r[WIDTH-1:1]} : {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
  assign idx_adv = dir_l ? (idx == '0 ? LAST : idx - IW'(1)) : (idx == LAST ? '0 : idx + IW'(1));
`ifdef JOHNSON_SELF_CORRECT_EN
  logic [WIDTH-1:0] q_inv;
  assign q_inv = ~q_r;
  // legal codes are a run of ones from bit 0, or a run of zeros from bit 0
  assign illegal = ((q_r & (q_r + WIDTH'(1))) != '0) && ((q_inv & (q_inv + WIDTH'(1))) != '0);
`else
  assign illegal = 1'b0;
`endif
  always_comb begin
    state_n = state;
    q_n = q_r;
    idx_n = idx;
    cnt_n = cnt;
    pe_n = pe_r;
    mode_n = mode_l;
    dir_n = dir_l;
    busy_n = busy_r;
    wrap_n = 1'b0;
    done_n = 1'b0;
    err_n = 1'b0;
    if (state == IDLE) begin
      if (bus.start && !bus.stop) begin
        state_n = RUN;
        busy_n = 1'b1;
        mode_n = bus.mode;
        dir_n = bus.dir;
        cnt_n = bus.num_cycles == '0 ? CNT_W'(1) : bus.num_cycles;
        q_n = '0;
        idx_n = '0;
        pe_n = (2*WIDTH)'(1);
      end
    end else if (illegal) begin
      q_n = '0;
      idx_n = '0;
      pe_n = (2*WIDTH)'(1);
      err_n = 1'b1;
    end else if (state == RUN && bus.stop && q_r == '0 && idx == '0) begin
      state_n = IDLE;
      busy_n = 1'b0;
      pe_n = '0;
      done_n = 1'b1;
    end else begin
      q_n = q_adv;
      idx_n = idx_adv;
      pe_n = (2*WIDTH)'(1) << idx_adv;
      state_n = (state == RUN && bus.stop) ? STOPPING : state;
      if (q_adv == '0) begin
        wrap_n = 1'b1;
        cnt_n = mode_l ? cnt : cnt - CNT_W'(1);
        // a stop that lands on the wrap edge ends the sequence right there
        if (state == STOPPING || bus.stop || (!mode_l && cnt == CNT_W'(1))) begin
          state_n = IDLE;
          busy_n = 1'b0;
          pe_n = '0;
          done_n = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      q_r <= '0;
      idx <= '0;
      cnt <= '0;
      pe_r <= '0;
      mode_l <= 1'b0;
      dir_l <= 1'b0;
      busy_r <= 1'b0;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= state_n;
      q_r <= q_n;
      idx <= idx_n;
      cnt <= cnt_n;
      pe_r <= pe_n;
      mode_l <= mode_n;
      dir_l <= dir_n;
      busy_r <= busy_n;
      wrap_r <= wrap_n;
      done_r <= done_n;
      err_r <= err_n;
    end
  end
  assign bus.q = q_r;
  assign bus.phase_en = pe_r;
  assign bus.busy = busy_r;
  assign bus.wrap = wrap_r;
  assign bus.done = done_r;
  assign bus.err = err_r;
endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb_johnson_seq_ctrl: directed scoreboard bench for johnson_seq_ctrl (WIDTH=4)
module tb_johnson_seq_ctrl;
  typedef struct packed {
    logic [3:0] q;
    logic [7:0] pe;
    logic busy;
    logic wrap;
    logic done;
    logic err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [3:0] fwd[8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
  logic [3:0] rev[8] = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
  johnson_seq_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();
  johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input exp_t e);
    n_assert++;
    assert ({bus.q, bus.phase_en, bus.busy, bus.wrap, bus.done, bus.err} === e)
    else begin
      n_fail++;
      $error("FAIL %s: got q=%h pe=%h busy=%b wrap=%b done=%b err=%b, expected q=%h pe=%h busy=%b wrap=%b done=%b err=%b",
             tag, bus.q, bus.phase_en, bus.busy, bus.wrap, bus.done, bus.err, e.q, e.pe, e.busy, e.wrap, e.done, e.err);
    end
  endtask
  task automatic push(input logic [3:0] q, input logic [7:0] pe, input logic b, input logic w, input logic d, input logic e);
    sb.push_back('{q: q, pe: pe, busy: b, wrap: w, done: d, err: e});
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else check(tag, sb.pop_front());
  endtask
  task automatic go(input logic m, input logic d, input logic [7:0] n);
    bus.start = 1'b1;
    bus.mode = m;
    bus.dir = d;
    bus.num_cycles = n;
    push(4'h0, 8'h01, 1, 0, 0, 0);
    tick("start");
    bus.start = 1'b0;
  endtask
  initial begin
    logic last;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.mode = 1'b0;
    bus.dir = 1'b0;
    bus.num_cycles = 8'd0;
    #12 rst = 1'b1;
    check("reset_state", '0);
    push(4'h0, 8'h00, 0, 0, 0, 0);
    tick("idle");
    go(1'b0, 1'b0, 8'd2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) begin
        last = (r == 1 && i == 7);
        if (r == 0 && i == 3) begin bus.start = 1'b1; bus.dir = 1'b1; bus.num_cycles = 8'd5; bus.mode = 1'b1; end
        if (r == 0 && i == 5) begin bus.start = 1'b0; bus.dir = 1'b0; bus.num_cycles = 8'd0; bus.mode = 1'b0; end
        push(fwd[i], last ? 8'h00 : 8'(1 << ((i + 1) % 8)), !last, i == 7, last, 0);
        tick("burst_fwd");
      end
    go(1'b0, 1'b1, 8'd1);
    for (int i = 0; i < 8; i++) begin
      push(rev[i], i == 7 ? 8'h00 : 8'(1 << (7 - i)), i != 7, i == 7, i == 7, 0);
      tick("burst_rev");
    end
    go(1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      push(fwd[i], i == 7 ? 8'h00 : 8'(1 << (i + 1)), i != 7, i == 7, i == 7, 0);
      tick("num_zero");
    end
    push(4'h0, 8'h00, 0, 0, 0, 0);
    tick("num_zero_idle");
    go(1'b1, 1'b0, 8'd1);
    for (int i = 0; i < 11; i++) begin
      push(fwd[i % 8], 8'(1 << ((i + 1) % 8)), 1, i == 7, 0, 0);
      tick("cont_run");
    end
    bus.stop = 1'b1;
    push(4'hF, 8'h10, 1, 0, 0, 0);
    tick("cont_stop");
    bus.stop = 1'b0;
    for (int i = 4; i < 8; i++) begin
      push(fwd[i], i == 7 ? 8'h00 : 8'(1 << (i + 1)), i != 7, i == 7, i == 7, 0);
      tick("cont_drain");
    end
    bus.start = 1'b1;
    bus.stop = 1'b1;
    push(4'h0, 8'h00, 0, 0, 0, 0);
    tick("start_stop_idle");
    bus.start = 1'b0;
    bus.stop = 1'b0;
    push(4'h0, 8'h00, 0, 0, 0, 0);
    tick("still_idle");
    go(1'b1, 1'b0, 8'd1);
    bus.stop = 1'b1;
    push(4'h0, 8'h00, 0, 0, 1, 0);
    tick("stop_at_zero");
    bus.stop = 1'b0;
    push(4'h0, 8'h00, 0, 0, 0, 0);
    tick("after_stop_zero");
    go(1'b0, 1'b0, 8'd1);
    push(4'h1, 8'h02, 1, 0, 0, 0);
    tick("pre_reset");
    push(4'h3, 8'h04, 1, 0, 0, 0);
    tick("pre_reset");
    rst = 1'b0;
    #1 check("async_reset", '0);
    push(4'h0, 8'h00, 0, 0, 0, 0);
    tick("reset_no_done");
    rst = 1'b1;
`ifdef JOHNSON_SELF_CORRECT_EN
    go(1'b1, 1'b0, 8'd1);
    push(4'h1, 8'h02, 1, 0, 0, 0);
    tick("sc_run");
    force dut.q_r = 4'b0101;
    #4 release dut.q_r;
    push(4'h0, 8'h01, 1, 0, 0, 1);
    tick("sc_correct");
    push(4'h1, 8'h02, 1, 0, 0, 0);
    tick("sc_resume");
    rst = 1'b0;
    #1 rst = 1'b1;
`endif
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: got %0d left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
